// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    UPDATE
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned BYTE_OFF_W  = 2;
  localparam int unsigned DEF_INDEX_W = 3;
  localparam int unsigned DEF_WORD_W  = 2;
  localparam int unsigned DEF_TAG_W   = 25;

  function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
    return 32 - $clog2(lines) - $clog2(words) - BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage: data and tag arrays (no reset) plus resettable valid/dirty bits.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES       = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_LINES),
  localparam int unsigned WORD_W = $clog2(WORDS_PER_BLOCK),
  localparam int unsigned TAG_W  = tag_width(NUM_LINES, WORDS_PER_BLOCK),
  localparam int unsigned BLK_W  = 32 * WORDS_PER_BLOCK
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_index,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [BLK_W-1:0]  o_block,
  input  logic              i_wr_en,
  input  logic [WORD_W-1:0] i_word,
  input  logic [3:0]        i_byte_en,
  input  logic [31:0]       i_wdata,
  input  logic              i_fill_en,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [BLK_W-1:0]  i_fill_block
);

  logic [BLK_W-1:0]     r_data [NUM_LINES];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_data[i_index];

  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_data[i_index] <= i_fill_block;
      r_tag[i_index]  <= i_fill_tag;
    end else if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byte_en[b]) begin
          r_data[i_index][int'(i_word) * 32 + b * 8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: hit logic and miss-handling FSM.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES       = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_LINES),
  localparam int unsigned WORD_W = $clog2(WORDS_PER_BLOCK),
  localparam int unsigned OFF_W  = WORD_W + BYTE_OFF_W,
  localparam int unsigned TAG_W  = tag_width(NUM_LINES, WORDS_PER_BLOCK),
  localparam int unsigned BLK_W  = 32 * WORDS_PER_BLOCK
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        READ_WRITE_EN,
  input  logic [31:0]       ADDRESS,
  input  logic [31:0]       WRITEDATA,
  output logic [31:0]       READDATA,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [31-OFF_W:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]  MEM_WRITEDATA,
  input  logic [BLK_W-1:0]  MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_e              r_state;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [31-OFF_W:0]   r_mem_addr;
  logic [BLK_W-1:0]    r_mem_wdata;

  logic [IDX_W-1:0]    w_index;
  logic [WORD_W-1:0]   w_word;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_size;
  logic                w_wr;
  logic                w_rd;
  logic                w_req;
  logic                w_valid;
  logic                w_dirty;
  logic [TAG_W-1:0]    w_line_tag;
  logic [BLK_W-1:0]    w_block;
  logic                w_hit;
  logic                w_wr_hit;
  logic [31:0]         w_word_data;
  logic [31:0]         w_rdata;
  logic [31:0]         w_wdata;
  logic [3:0]          w_byte_en;

  assign w_index = ADDRESS[OFF_W +: IDX_W];
  assign w_word  = ADDRESS[BYTE_OFF_W +: WORD_W];
  assign w_tag   = ADDRESS[31 -: TAG_W];
  assign w_size  = READ_WRITE_EN[1:0];
  // Write takes precedence when both read and write are requested.
  assign w_wr    = READ_WRITE_EN[3];
  assign w_rd    = READ_WRITE_EN[2] & ~READ_WRITE_EN[3];
  assign w_req   = READ_WRITE_EN[3] | READ_WRITE_EN[2];

  assign w_hit       = w_valid && (w_line_tag == w_tag);
  assign w_wr_hit    = (r_state == IDLE) && w_wr && w_hit;
  assign w_word_data = w_block[int'(w_word) * 32 +: 32];

  always_comb begin
    w_byte_en = 4'b1111;
    w_wdata   = WRITEDATA;
    w_rdata   = w_word_data;
    case (w_size)
      SIZE_BYTE: begin
        w_byte_en = 4'b0001 << ADDRESS[1:0];
        w_wdata   = {4{WRITEDATA[7:0]}};
        w_rdata   = {24'b0, w_word_data[int'(ADDRESS[1:0]) * 8 +: 8]};
      end
      SIZE_HALF: begin
        w_byte_en = ADDRESS[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{WRITEDATA[15:0]}};
        w_rdata   = {16'b0, (ADDRESS[1] ? w_word_data[31:16] : w_word_data[15:0])};
      end
      default: ;
    endcase
  end

  assign READDATA      = ((r_state == IDLE) && w_rd && w_hit) ? w_rdata : 32'b0;
  assign BUSYWAIT      = (r_state != IDLE) || (w_req && !w_hit);
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            if (w_valid && w_dirty) begin
              r_state     <= WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {w_line_tag, w_index};
              r_mem_wdata <= w_block;
            end else begin
              r_state    <= ALLOCATE;
              r_mem_read <= 1'b1;
              r_mem_addr <= {w_tag, w_index};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            r_state     <= ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {w_tag, w_index};
          end
        end
        ALLOCATE: begin
          if (!MEM_BUSYWAIT) begin
            r_state    <= UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        UPDATE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  data_cache_array #(
    .NUM_LINES       (NUM_LINES),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_array (
    .i_clk        (CLK),
    .i_rst_n      (RESET),
    .i_index      (w_index),
    .o_valid      (w_valid),
    .o_dirty      (w_dirty),
    .o_tag        (w_line_tag),
    .o_block      (w_block),
    .i_wr_en      (w_wr_hit),
    .i_word       (w_word),
    .i_byte_en    (w_byte_en),
    .i_wdata      (w_wdata),
    .i_fill_en    (r_state == UPDATE),
    .i_fill_tag   (w_tag),
    .i_fill_block (MEM_READDATA)
  );

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: fills, hits, byte/half access, eviction, stall and reset.
module tb_data_cache;

  logic         CLK;
  logic         RESET;
  logic [3:0]   READ_WRITE_EN;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_checks = 0;
  int n_errors = 0;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ_WRITE_EN (READ_WRITE_EN),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] rwe, input logic [31:0] addr, input logic [31:0] wd);
    READ_WRITE_EN = rwe;
    ADDRESS       = addr;
    WRITEDATA     = wd;
    #1;
  endtask

  initial begin
    RESET         = 1'b0;
    READ_WRITE_EN = 4'b0000;
    ADDRESS       = 32'h0;
    WRITEDATA     = 32'h0;
    MEM_READDATA  = {32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF};
    MEM_BUSYWAIT  = 1'b1;
    tick();
    tick();
    chk("rst_mem_read", MEM_READ, 1'b0);
    chk("rst_mem_write", MEM_WRITE, 1'b0);
    chk("rst_busywait", BUSYWAIT, 1'b0);
    chk("rst_readdata", READDATA, 32'h0);
    RESET = 1'b1;

    // Cold word read with a 5-cycle memory stall in ALLOCATE
    drive(4'b0110, 32'h0000_0010, 32'h0);
    chk("cold_busy_comb", BUSYWAIT, 1'b1);
    chk("cold_idle_no_read", MEM_READ, 1'b0);
    tick();
    chk("alloc_addr", MEM_ADDRESS, 28'h0000001);
    chk("alloc_no_write", MEM_WRITE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_read", MEM_READ, 1'b1);
      chk("stall_busy", BUSYWAIT, 1'b1);
      tick();
    end
    chk("stall_end_mem_read", MEM_READ, 1'b1);
    MEM_BUSYWAIT = 1'b0;
    tick();
    chk("update_mem_read", MEM_READ, 1'b0);
    chk("update_busy", BUSYWAIT, 1'b1);
    tick();
    chk("cold_hit_busy", BUSYWAIT, 1'b0);
    chk("cold_hit_data", READDATA, 32'hDEADBEEF);

    // Sub-word reads on the filled line
    drive(4'b0101, 32'h0000_0016, 32'h0);
    chk("half_hi_bit0_ignored", READDATA, 32'h0000CAFE);
    drive(4'b0101, 32'h0000_0014, 32'h0);
    chk("half_lo", READDATA, 32'h0000F00D);
    drive(4'b0100, 32'h0000_001B, 32'h0);
    chk("byte3", READDATA, 32'h00000001);
    drive(4'b0100, 32'h0000_0018, 32'h0);
    chk("byte0", READDATA, 32'h00000067);
    drive(4'b0111, 32'h0000_001B, 32'h0);
    chk("size11_as_word", READDATA, 32'h01234567);

    // Write hits
    drive(4'b1000, 32'h0000_0013, 32'h0000_00AB);
    chk("wbyte_busy", BUSYWAIT, 1'b0);
    chk("wbyte_no_readdata", READDATA, 32'h0);
    tick();
    drive(4'b0110, 32'h0000_0010, 32'h0);
    chk("wbyte_result", READDATA, 32'hABADBEEF);
    chk("wbyte_no_mem_read", MEM_READ, 1'b0);
    chk("wbyte_no_mem_write", MEM_WRITE, 1'b0);
    drive(4'b1001, 32'h0000_0017, 32'h0000_1234);
    tick();
    drive(4'b1110, 32'h0000_001C, 32'h55AA55AA);
    chk("rw_as_write_readdata", READDATA, 32'h0);
    tick();
    drive(4'b0110, 32'h0000_001C, 32'h0);
    chk("rw_write_result", READDATA, 32'h55AA55AA);
    drive(4'b0110, 32'h0000_0014, 32'h0);
    chk("whalf_result", READDATA, 32'h1234F00D);

    // Dirty eviction of line 1 by tag 1
    MEM_READDATA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    drive(4'b0110, 32'h0000_0090, 32'h0);
    chk("evict_busy_comb", BUSYWAIT, 1'b1);
    tick();
    chk("wb_mem_write", MEM_WRITE, 1'b1);
    chk("wb_mem_read", MEM_READ, 1'b0);
    chk("wb_addr", MEM_ADDRESS, 28'h0000001);
    chk("wb_data", MEM_WRITEDATA, {32'h55AA55AA, 32'h01234567, 32'h1234F00D, 32'hABADBEEF});
    tick();
    chk("evict_alloc_read", MEM_READ, 1'b1);
    chk("evict_alloc_write", MEM_WRITE, 1'b0);
    chk("evict_alloc_addr", MEM_ADDRESS, 28'h0000009);
    tick();
    chk("evict_update_busy", BUSYWAIT, 1'b1);
    tick();
    chk("evict_hit_busy", BUSYWAIT, 1'b0);
    chk("evict_hit_data", READDATA, 32'h11111111);

    // Idle request to an uncached address
    drive(4'b0000, 32'h0000_0300, 32'h0);
    chk("idle_busy", BUSYWAIT, 1'b0);
    chk("idle_readdata", READDATA, 32'h0);
    tick();
    chk("idle_no_read", MEM_READ, 1'b0);
    chk("idle_no_write", MEM_WRITE, 1'b0);
    chk("idle_busy_after", BUSYWAIT, 1'b0);

    // Reset in the middle of ALLOCATE
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    drive(4'b0110, 32'h0000_0200, 32'h0);
    tick();
    chk("rst_alloc_read", MEM_READ, 1'b1);
    chk("rst_alloc_addr", MEM_ADDRESS, 28'h0000020);
    RESET = 1'b0;
    #1;
    chk("rst_async_read", MEM_READ, 1'b0);
    chk("rst_async_write", MEM_WRITE, 1'b0);
    tick();
    RESET = 1'b1;
    #1;
    chk("rerd_busy", BUSYWAIT, 1'b1);
    chk("rerd_idle_read", MEM_READ, 1'b0);
    tick();
    chk("rerd_alloc_read", MEM_READ, 1'b1);
    chk("rerd_alloc_addr", MEM_ADDRESS, 28'h0000020);
    MEM_BUSYWAIT = 1'b0;
    tick();
    tick();
    chk("rerd_hit_busy", BUSYWAIT, 1'b0);
    chk("rerd_hit_data", READDATA, 32'hA0A0A0A0);
    drive(4'b0110, 32'h0000_0090, 32'h0);
    chk("line1_invalid_after_rst", BUSYWAIT, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL have parameter NUM_LINES, default 8, meaning number of direct-mapped lines (power of two).
REQ-002 The module SHALL have parameter WORDS_PER_BLOCK, default 4, meaning 32-bit words per line (16-byte block).
REQ-003 The module SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 The module SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port READ_WRITE_EN  input  4  CPU request: [3]=write, [2]=read, [1:0]=size (00 byte, 01 half, 10 word); 4'b0000 means idle.
REQ-006 The module SHALL have port ADDRESS  input  32  CPU byte address.
REQ-007 The module SHALL have port WRITEDATA  input  32  CPU store data, right-justified.
REQ-008 The module SHALL have port READDATA  output  32  load data, right-justified, zero-extended (the CPU performs sign extension).
REQ-009 The module SHALL have port BUSYWAIT  output  1  stall to CPU; the CPU holds its request stable while high.
REQ-010 The module SHALL have ports MEM_READ, MEM_WRITE  output  1 each  block-memory requests.
REQ-011 The module SHALL have ports MEM_ADDRESS  output  28  block address (byte address [31:4]); MEM_WRITEDATA  output  128  evicted block; MEM_READDATA  input  128  fetched block; MEM_BUSYWAIT  input  1  memory busy.

Function
REQ-012 Address split SHALL be tag=[31:7] (25 bits), index=[6:4], word=[3:2], byte=[1:0] at default parameters.
REQ-013 A request with read and write both set SHALL be treated as a write.
REQ-014 Hit (valid and tag equal) SHALL be evaluated combinationally; on a hit, BUSYWAIT SHALL be 0 in the same cycle and READDATA SHALL be valid in that cycle.
REQ-015 A write hit SHALL update only the addressed byte(s) at the next rising edge and set the line's dirty bit.
REQ-016 Half accesses SHALL use byte offset [1] only; bit [0] SHALL be ignored; word accesses SHALL ignore [1:0]; size 11 SHALL be treated as word.
REQ-017 On a miss in IDLE, BUSYWAIT SHALL rise combinationally in the same cycle.
REQ-018 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-019 IDLE->WRITEBACK on a miss to a valid dirty line; IDLE->ALLOCATE on a miss to a clean or invalid line.
REQ-020 WRITEBACK SHALL drive MEM_WRITE=1 with the victim {tag,index} and block data, and SHALL move to ALLOCATE on the first edge where MEM_BUSYWAIT=0.
REQ-021 ALLOCATE SHALL drive MEM_READ=1 with the request {tag,index} and SHALL move to UPDATE on the first edge where MEM_BUSYWAIT=0.
REQ-022 UPDATE SHALL write MEM_READDATA, the new tag, valid=1 and dirty=0 into the line, then return to IDLE, where the request re-evaluates as a hit.
REQ-023 BUSYWAIT SHALL be 1 in WRITEBACK, ALLOCATE and UPDATE.
REQ-024 MEM_READ and MEM_WRITE SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and UPDATE.
REQ-025 An idle request (4'b0000) SHALL never cause a miss or a state change.
REQ-026 READDATA SHALL be 0 when no read hit is present.

Reset
REQ-027 RESET low SHALL immediately clear all valid and dirty bits, force state IDLE, and drive MEM_READ=0 and MEM_WRITE=0, including mid-WRITEBACK or mid-ALLOCATE (the in-flight transfer is abandoned).
REQ-028 Data and tag arrays SHALL need no reset.
REQ-029 After reset, BUSYWAIT SHALL be 0 unless a valid request is present.

Structure
REQ-030 Package data_cache_pkg SHALL hold the state enum, size encodings, and tag/index/offset width constants.
REQ-031 Storage (data, tag, valid, dirty arrays with byte-enable write) SHALL be a single sub-module, data_cache_array; the FSM and hit logic SHALL remain in data_cache.

Verification
REQ-032 Cold read: after reset, word read at 0x00000010 -> BUSYWAIT=1, ALLOCATE with MEM_ADDRESS=0x0000001, UPDATE, then hit; READDATA equals word 0 of MEM_READDATA.
REQ-033 Write hit: byte write 0xAB to 0x00000013 after line fill -> next word read at 0x00000010 returns 0xAB in bits [31:24] with the other bytes unchanged; no memory access occurs.
REQ-034 Dirty eviction: line 1 dirty with tag 0, then read 0x00000090 -> WRITEBACK with MEM_ADDRESS=0x0000001, then ALLOCATE with MEM_ADDRESS=0x0000009, then hit.
REQ-035 Memory stall: MEM_BUSYWAIT held high 5 cycles in ALLOCATE -> state holds and BUSYWAIT stays 1 for the whole stall.
REQ-036 Reset mid-ALLOCATE: RESET low for one cycle -> MEM_READ=0 immediately, and a re-read of the same address misses again.
REQ-037 Half read at 0x00000016 (bit[0] ignored) -> returns the upper halfword of word 1, zero-extended.
